// File: rtl/fetch_ctrl.sv
// Instruction fetch controller for a 5-stage pipeline.
// Tracks the fetch address, waits on a variable-latency instruction memory,
// drains the wrong-path word after a redirect arrives while a fetch is
// outstanding, and stops fetching on HLT until a redirect proves it wrong-path.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   redirect, redirect_pc taken branch from MEM and its target
//   stall                ID hazard stall, hold the fetch address
//   halt                 HLT decoded in ID
//   imem_rdy             memory returns the word for pc this cycle
//   pc, pc_plus2         current fetch address and pc + 2
//   imem_req             fetch request to instruction memory
//   fetch_valid          IF/ID may capture the returned word
//   flush_ifid/idex/exmem squash the younger pipeline registers
//   halted               fetch stopped on HLT
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_rdy,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        imem_req,
  output logic        fetch_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        halted
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  // Fetch addresses are halfword aligned.
  localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] target;
  logic [15:0] pc_inc;

  assign target = {redirect_pc[15:1], 1'b0};
  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    unique case (state_q)
      StRun, StWait: begin
        if (redirect) begin
          if (imem_rdy) begin
            pc_d    = target;
            state_d = StRun;
          end else begin
            // Word for the old pc is still in flight; discard it first.
            pending_d = target;
            state_d   = StDrain;
          end
        end else if (halt) begin
          state_d = StHalt;
        end else if (!imem_rdy) begin
          state_d = StWait;
        end else begin
          state_d = StRun;
          if (!stall) pc_d = pc_inc;
        end
      end
      StDrain: begin
        if (imem_rdy) begin
          pc_d    = redirect ? target : pending_q;
          state_d = StRun;
        end else if (redirect) begin
          pending_d = target;
        end
      end
      StHalt: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pc_q      <= ResetPcAligned;
      pending_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus2    = pc_inc;
  assign flush_ifid  = redirect;
  assign flush_idex  = redirect;
  assign flush_exmem = redirect;
  // Qualified by rst_n so nothing requests or validates while reset is held.
  assign imem_req    = rst_n && (state_q != StHalt);
  assign fetch_valid = rst_n && ((state_q == StRun) || (state_q == StWait)) && imem_rdy
                       && !redirect;
  assign halted      = rst_n && (state_q == StHalt);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_rdy;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_exmem;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .halt       (halt),
    .imem_rdy   (imem_rdy),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .imem_req   (imem_req),
    .fetch_valid(fetch_valid),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .flush_exmem(flush_exmem),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then step off it before checking or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load pc through a same-cycle redirect with memory ready.
  task automatic jump(input logic [15:0] t);
    redirect = 1'b1; redirect_pc = t; imem_rdy = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 16'h1234; stall = 1'b0; halt = 1'b0;
    imem_rdy = 1'b1;
    #2;
    checks++; if (pc !== 16'h0000) begin failures++;
      $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
    checks++; if ({imem_req, fetch_valid, halted} !== 3'b000) begin failures++;
      $display("FAIL reset_outs got=%b exp=%b", {imem_req, fetch_valid, halted}, 3'b000); end
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b111) begin failures++;
      $display("FAIL reset_flush got=%b exp=%b", {flush_ifid, flush_idex, flush_exmem}, 3'b111); end
    tick();
    redirect = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (pc !== 16'h0000 || fetch_valid !== 1'b1 || imem_req !== 1'b1) begin
      failures++; $display("FAIL release_pc got=%h/%b exp=0000/1", pc, fetch_valid); end
    checks++; if (pc_plus2 !== 16'h0002) begin failures++;
      $display("FAIL pc_plus2 got=%h exp=%h", pc_plus2, 16'h0002); end
    tick();
    checks++; if (pc !== 16'h0002 || fetch_valid !== 1'b1) begin failures++;
      $display("FAIL run_pc1 got=%h/%b exp=0002/1", pc, fetch_valid); end
    tick();
    checks++; if (pc !== 16'h0004) begin failures++;
      $display("FAIL run_pc2 got=%h exp=%h", pc, 16'h0004); end
  endtask

  task automatic test_redirect();
    jump(16'h0010);
    checks++; if (pc !== 16'h0010) begin failures++;
      $display("FAIL jump_0010 got=%h exp=%h", pc, 16'h0010); end
    redirect = 1'b1; redirect_pc = 16'h0041;
    #1;
    checks++; if ({flush_ifid, flush_idex, flush_exmem, fetch_valid} !== 4'b1110) begin
      failures++; $display("FAIL redir_flush got=%b exp=%b",
        {flush_ifid, flush_idex, flush_exmem, fetch_valid}, 4'b1110); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (pc !== 16'h0040) begin failures++;
      $display("FAIL redir_pc got=%h exp=%h", pc, 16'h0040); end
    checks++; if ({flush_ifid, flush_idex, flush_exmem} !== 3'b000) begin failures++;
      $display("FAIL redir_flush_off got=%b exp=000", {flush_ifid, flush_idex, flush_exmem}); end
  endtask

  task automatic test_wait();
    imem_rdy = 1'b0;
    tick();
    checks++; if (pc !== 16'h0040 || fetch_valid !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL wait_hold got=%h/%b exp=0040/0", pc, fetch_valid); end
    imem_rdy = 1'b1; stall = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin failures++;
      $display("FAIL wait_valid got=%b exp=1", fetch_valid); end
    tick();
    checks++; if (pc !== 16'h0040) begin failures++;
      $display("FAIL wait_stall got=%h exp=%h", pc, 16'h0040); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 16'h0042) begin failures++;
      $display("FAIL wait_inc got=%h exp=%h", pc, 16'h0042); end
  endtask

  task automatic test_drain();
    jump(16'h0020);
    imem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (pc !== 16'h0020 || fetch_valid !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL drain_enter got=%h/%b/%b exp=0020/0/1", pc, fetch_valid,
        imem_req); end
    halt = 1'b1; stall = 1'b1;
    tick();
    imem_rdy = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0 || pc !== 16'h0020) begin failures++;
      $display("FAIL drain_discard got=%h/%b exp=0020/0", pc, fetch_valid); end
    tick();
    halt = 1'b0; stall = 1'b0;
    #1;
    checks++; if (pc !== 16'h0100 || fetch_valid !== 1'b1 || halted !== 1'b0) begin
      failures++; $display("FAIL drain_exit got=%h/%b exp=0100/1", pc, fetch_valid); end
    // Latest redirect during DRAIN wins.
    imem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_pc = 16'h0301;
    tick();
    redirect = 1'b0; imem_rdy = 1'b1;
    tick();
    checks++; if (pc !== 16'h0300) begin failures++;
      $display("FAIL drain_latest got=%h exp=%h", pc, 16'h0300); end
  endtask

  task automatic test_halt();
    int bad;
    jump(16'h0030);
    halt = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0030) begin
      failures++; $display("FAIL halt_enter got=%b/%b/%h exp=1/0/0030", halted, imem_req, pc); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      imem_rdy = i[0];
      tick();
      if (pc !== 16'h0030 || halted !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL halt_hold got=%0d bad cycles exp=0", bad); end
    halt = 1'b0; imem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 16'h0008;
    tick();
    redirect = 1'b0; imem_rdy = 1'b1;
    #1;
    checks++; if (pc !== 16'h0008 || halted !== 1'b0 || imem_req !== 1'b1) begin
      failures++; $display("FAIL halt_exit got=%h/%b exp=0008/0", pc, halted); end
  endtask

  task automatic test_back_to_back();
    halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0050;
    tick();
    halt = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (pc !== 16'h0050 || halted !== 1'b0) begin failures++;
      $display("FAIL halt_vs_redir got=%h/%b exp=0050/0", pc, halted); end
    jump(16'hFFFE);
    stall = 1'b1;
    tick();
    checks++; if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin failures++;
      $display("FAIL wrap_stall got=%h/%h exp=fffe/0000", pc, pc_plus2); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 16'h0000) begin failures++;
      $display("FAIL wrap_inc got=%h exp=%h", pc, 16'h0000); end
  endtask

  task automatic test_reset_midflight();
    jump(16'h0100);
    imem_rdy = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300;
    tick();
    redirect = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 16'h0000 || imem_req !== 1'b0) begin failures++;
      $display("FAIL rst_drain_async got=%h/%b exp=0000/0", pc, imem_req); end
    #1;
    rst_n = 1'b1; imem_rdy = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin failures++;
      $display("FAIL rst_drain_valid got=%b exp=1", fetch_valid); end
    tick();
    checks++; if (pc !== 16'h0002) begin failures++;
      $display("FAIL rst_drain_nopend got=%h exp=%h", pc, 16'h0002); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || pc !== 16'h0000) begin failures++;
      $display("FAIL rst_halt got=%b/%h exp=0/0000", halted, pc); end
    rst_n = 1'b1;
    tick();
    checks++; if (pc !== 16'h0002 || halted !== 1'b0) begin failures++;
      $display("FAIL rst_halt_resume got=%h/%b exp=0002/0", pc, halted); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_wait();
    test_drain();
    test_halt();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: redirect  input  1  taken branch resolved in MEM (branchtaken).
REQ-005 SHALL have port: redirect_pc  input  16  branch target from MEM.
REQ-006 SHALL have port: stall  input  1  ID hazard stall; hold fetch address.
REQ-007 SHALL have port: halt  input  1  HLT decoded in ID.
REQ-008 SHALL have port: imem_rdy  input  1  instruction memory returns the word for pc this cycle.
REQ-009 SHALL have port: pc  output  16  current fetch address.
REQ-010 SHALL have port: pc_plus2  output  16  pc + 2, mod 2^16, combinational.
REQ-011 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-012 SHALL have port: fetch_valid  output  1  IF/ID may capture the returned word.
REQ-013 SHALL have port: flush_ifid, flush_idex, flush_exmem  output  1 each  squash the three younger pipeline registers.
REQ-014 SHALL have port: halted  output  1  fetch stopped on HLT.

Function
REQ-015 SHALL implement states RUN, WAIT, DRAIN, HALT, plus a 16-bit pending-target register.
REQ-016 SHALL drive all three flush outputs equal to redirect, combinationally, in every state.
REQ-017 SHALL force bit 0 of any loaded target to 0; pc bit 0 is always 0.
REQ-018 SHALL wrap pc from 16'hFFFE to 16'h0000 on increment.
REQ-019 SHALL drive imem_req = 1 in RUN, WAIT, DRAIN; 0 in HALT.
REQ-020 SHALL drive fetch_valid = 1 only when state is RUN or WAIT, imem_rdy = 1, redirect = 0.
REQ-021 SHALL apply input priority: redirect > halt > imem_rdy = 0 > stall > increment.
REQ-022 RUN: redirect & imem_rdy -> pc <= redirect_pc, stay RUN.
REQ-023 RUN: redirect & !imem_rdy -> pending <= redirect_pc, go DRAIN, pc holds.
REQ-024 RUN: halt -> go HALT, pc holds.
REQ-025 RUN: !imem_rdy -> go WAIT, pc holds.
REQ-026 RUN: stall -> pc holds.
REQ-027 RUN: otherwise -> pc <= pc + 2.
REQ-028 WAIT: redirect handled exactly as in RUN (REQ-022/023).
REQ-029 WAIT: halt -> go HALT.
REQ-030 WAIT: imem_rdy -> go RUN; pc <= pc + 2 unless stall.
REQ-031 WAIT: otherwise -> hold.
REQ-032 DRAIN: fetch_valid = 0, the outstanding wrong-path word is discarded.
REQ-033 DRAIN: new redirect -> pending <= redirect_pc (latest wins).
REQ-034 DRAIN: imem_rdy -> pc <= pending (or redirect_pc if redirect same cycle), go RUN; halt and stall ignored.
REQ-035 HALT: halted = 1, pc holds.
REQ-036 HALT: only redirect exits -> pc <= redirect_pc, go RUN (HLT was wrong-path).
REQ-037 SHALL ignore halt when redirect is asserted the same cycle; no HALT entry.

Reset
REQ-038 SHALL, while rst_n = 0, asynchronously force state RUN, pc = RESET_PC, pending = 16'h0000.
REQ-039 SHALL, while rst_n = 0, hold imem_req, fetch_valid, halted = 0; flush outputs follow redirect.
REQ-040 SHALL resume fetch from RESET_PC on the first rising edge after rst_n deasserts.
REQ-041 SHALL on reset mid-DRAIN or mid-HALT discard pending target and halted state immediately.

Verification
REQ-042 Reset release, imem_rdy = 1 always -> pc 0000, 0002, 0004 on successive edges; fetch_valid = 1.
REQ-043 pc = 0010, redirect = 1, redirect_pc = 0041, imem_rdy = 1 -> all flush = 1 that cycle; next pc = 0040.
REQ-044 pc = 0020, imem_rdy = 0, redirect to 0100 -> DRAIN, pc holds 0020; imem_rdy = 1 two cycles later -> fetch_valid = 0, next pc = 0100.
REQ-045 halt = 1 at pc = 0030 -> HALT, imem_req = 0, halted = 1, pc holds for 10 cycles; then redirect to 0008 -> RUN, pc = 0008.
REQ-046 halt and redirect both asserted, redirect_pc = 0050 -> no HALT, pc = 0050; stall = 1 at pc = FFFE -> pc holds; stall released -> pc = 0000.
REQ-047 rst_n low asynchronously while in DRAIN -> pc = RESET_PC with no clock edge, no pending target applied after release.
